wave_display: RTL

- Downstream consumer of the wave capture stage: reads the ping-pong sample RAM the capture stage fills and renders the captured 256-sample waveform as a connected trace on the VGA raster.
- Generates RAM read addresses from the pixel coordinate and returns pixel colour with fixed 2-cycle latency.
- Raises wave_display_idle when the raster is outside the wave window, so the capture stage can swap buffers.

---
 rtl/wave_display_pkg.sv | 47 ++++
 rtl/wave_sample_history.sv | 77 +++++++
 rtl/wave_display.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wave_display_pkg.sv
// -----------------------------------------------------------------------------
// wave_display_pkg
// Shared constants, types and helpers for the waveform display pipeline.
//   WAVE_X_SEL   : x[10:9] value that selects the wave window (x 512..1023)
//   SAMPLE_MAX   : full-scale sample value; row = SAMPLE_MAX - sample
//   RGB_W        : packed {r,g,b} width
//   WIN_*        : bit positions used to decode the wave window
// -----------------------------------------------------------------------------
package wave_display_pkg;

  localparam int RGB_W  = 24;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int COL_W  = 8;
  localparam int ADDR_W = COL_W + 1;

  localparam logic [1:0]       WAVE_X_SEL = 2'b01;
  localparam logic [COL_W-1:0] SAMPLE_MAX = 8'd255;

  // Window decode: x[WIN_X_MSB:WIN_X_LSB] == WAVE_X_SEL and y[WIN_Y_BIT] == 0.
  localparam int WIN_X_MSB = 10;
  localparam int WIN_X_LSB = 9;
  localparam int WIN_Y_BIT = 9;

  typedef logic [COL_W-1:0] row_t;

  // Pixel context carried alongside the RAM read so it lines up with read_value.
  // Only the bits the later stages consume are kept: the sample column x[8:1]
  // and the doubled-line row y[8:1].
  typedef struct packed {
    logic             valid;
    logic             in_window;
    logic [COL_W-1:0] col;
    row_t             line_row;
  } stage1_t;

  function automatic logic in_wave_window(input logic [X_W-1:0] px,
                                          input logic [Y_W-1:0] py);
    return (px[WIN_X_MSB:WIN_X_LSB] == WAVE_X_SEL) && !py[WIN_Y_BIT];
  endfunction

  // Larger samples are drawn higher on screen, i.e. on a smaller row.
  function automatic row_t sample_to_row(input logic [COL_W-1:0] sample);
    return SAMPLE_MAX - sample;
  endfunction

endpackage : wave_display_pkg

// File: rtl/wave_sample_history.sv
// -----------------------------------------------------------------------------
// wave_sample_history
// Remembers the screen rows of the previous and current sample columns so the
// trace can be drawn as a vertical segment joining neighbouring samples.
//   clk, rst_n  : clock, asynchronous active-low reset
//   update      : stage-1 pixel is valid and inside the wave window
//   col         : sample column of the stage-1 pixel (x[8:1])
//   sample_row  : row of the sample returned by the RAM for that column
//   lo_row      : min(prev_row, curr_row) after this cycle's update
//   hi_row      : max(prev_row, curr_row) after this cycle's update
// -----------------------------------------------------------------------------
module wave_sample_history
  import wave_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic [COL_W-1:0] col,
  input  row_t             sample_row,
  output row_t             lo_row,
  output row_t             hi_row
);

  row_t             prev_row;
  row_t             curr_row;
  row_t             prev_next;
  row_t             curr_next;
  logic [COL_W-1:0] last_col;

  // Column 0 restarts the segment on itself so nothing is drawn back to the
  // end of the previous line. Testing it before the column-change rule also
  // means the first pixel after reset (last_col already 0) is still captured.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    prev_next = prev_row;
    curr_next = curr_row;
    if (update) begin
      if (col == '0) begin
        prev_next = sample_row;
        curr_next = sample_row;
      end else if (col != last_col) begin
        prev_next = curr_row;
        curr_next = sample_row;
      end
    end
  end

  // The segment bounds use the freshly updated rows so the first pixel of a
  // new column already shows the segment ending at that column's sample.
  always_comb begin
    if (prev_next <= curr_next) begin
      lo_row = prev_next;
      hi_row = curr_next;
    end else begin
      lo_row = curr_next;
      hi_row = prev_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is written with <= so every flop samples the
      // values from before the edge; = here would make order-dependent logic.
      prev_row <= '0;
      curr_row <= '0;
      last_col <= '0;
    end else begin
      prev_row <= prev_next;
      curr_row <= curr_next;
      if (update) begin
        last_col <= col;
      end
    end
  end

endmodule : wave_sample_history

// File: rtl/wave_display.sv
// -----------------------------------------------------------------------------
// wave_display
// Renders the 256-sample waveform held in the capture stage's ping-pong RAM as
// a connected trace in the window x 512..1023, y 0..511 of the VGA raster.
// Each sample spans 2 columns and each row is 2 lines tall. Colour output has
// a fixed 2-cycle latency from x/y/valid.
//   clk, reset        : clock, asynchronous active-low reset
//   x, y, valid       : pixel coordinate from VGA timing, active-video flag
//   read_index        : RAM half released for display, latched at frame start
//   read_value        : RAM data, valid 1 cycle after read_address
//   read_address      : {display_index, x[8:1]}
//   valid_pixel       : valid delayed by 2 cycles, qualifies r/g/b
//   r, g, b           : pixel colour (0 outside the window or when not valid)
//   wave_display_idle : registered y[9]; lets the capture stage swap buffers
// -----------------------------------------------------------------------------
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [RGB_W-1:0] WAVE_COLOR = 24'hFFFFFF,
  parameter logic [RGB_W-1:0] BG_COLOR   = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              valid,
  input  logic              read_index,
  input  logic [COL_W-1:0]  read_value,
  output logic [ADDR_W-1:0] read_address,
  output logic              valid_pixel,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              wave_display_idle
);

  logic             display_index;
  logic             frame_start;
  stage1_t          s1_d;
  stage1_t          s1_q;
  row_t             sample_row;
  row_t             lo_row;
  row_t             hi_row;
  logic             draw;
  logic             lit;
  logic [RGB_W-1:0] pix_color;
  logic [RGB_W-1:0] rgb_q;

  // ---------------------------------------------------------------------------
  // Frame latch: the RAM half is chosen once per frame so a buffer swap by the
  // capture stage never tears the trace mid-frame.
  // ---------------------------------------------------------------------------
  assign frame_start = valid && (x == '0) && (y == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display_index <= 1'b0;
    end else if (frame_start) begin
      display_index <= read_index;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: RAM address straight from the pixel column.
  // ---------------------------------------------------------------------------
  assign read_address = {display_index, x[COL_W:1]};

  // ---------------------------------------------------------------------------
  // Stage 1: pixel context delayed to line up with read_value.
  // ---------------------------------------------------------------------------
  assign s1_d = '{
    valid:     valid,
    in_window: in_wave_window(x, y),
    col:       x[COL_W:1],
    line_row:  y[COL_W:1]
  };

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign sample_row = sample_to_row(read_value);
  assign draw       = s1_q.valid && s1_q.in_window;

  wave_sample_history u_history (
    .clk        (clk),
    .rst_n      (reset),
    .update     (draw),
    .col        (s1_q.col),
    .sample_row (sample_row),
    .lo_row     (lo_row),
    .hi_row     (hi_row)
  );

  assign lit = draw && (s1_q.line_row >= lo_row) && (s1_q.line_row <= hi_row);

  always_comb begin
    pix_color = '0;
    if (draw) begin
      pix_color = lit ? WAVE_COLOR : BG_COLOR;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered colour output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pixel <= 1'b0;
      rgb_q       <= '0;
    end else begin
      valid_pixel <= s1_q.valid;
      rgb_q       <= pix_color;
    end
  end

  assign {r, g, b} = rgb_q;

  // Idle tracks the raster row only (not valid), so it stays high through the
  // lower half of the frame and vertical blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wave_display_idle <= 1'b0;
    end else begin
      wave_display_idle <= y[WIN_Y_BIT];
    end
  end

endmodule : wave_display
